uart_loopback_echo: RTL and testbench



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx.sv | 115 +++++++++++
 rtl/uart_tx.sv | 107 ++++++++++
 rtl/uart_loopback_echo.sv | 72 +++++++
 tb/tb_uart_loopback_echo.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo datapath.
package uart_pkg;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    localparam logic        StartBit       = 1'b0;
    localparam logic        StopBit        = 1'b1;
    localparam int unsigned OversampleRate = 8;

    // Wide enough for 0xFFFF * 8 clock cycles per bit.
    localparam int unsigned CntWidth = 19;

    // Clock cycles per bit; a prescale of 0 behaves like 1.
    function automatic logic [CntWidth-1:0] bit_cycles(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return CntWidth'(p) * CntWidth'(OversampleRate);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle valid pulse per good frame. Framing errors are dropped silently.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter logic [15:0] Prescale  = 16'd1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rx_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o
);

    localparam logic [CntWidth-1:0] BitCycles = bit_cycles(Prescale);
    localparam logic [CntWidth-1:0] HalfBit   = BitCycles >> 1;
    localparam logic [CntWidth-1:0] LastCnt   = BitCycles - CntWidth'(1);
    localparam int unsigned         IdxWidth  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(DataWidth - 1);

    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 valid_q, valid_d;

    assign rx_s    = sync_q[1];
    assign data_o  = shift_q;
    assign valid_o = valid_q;

    // Next-state logic: synchronizer shift plus the receive FSM.
    always_comb begin
        sync_d  = {sync_q[0], rx_i};
        state_d = state_q;
        cnt_d   = cnt_q + CntWidth'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;

        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (rx_s == StartBit) begin
                    // Start counting from half a bit so later samples land mid-bit.
                    state_d = RxStart;
                    cnt_d   = HalfBit;
                end
            end
            RxStart: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (rx_s == StartBit) ? RxData : RxIdle;
                end
            end
            RxData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DataWidth-1:1]};
                    if (idx_q == LastIdx) begin
                        state_d = RxStop;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            RxStop: begin
                if (ferr_q) begin
                    // Bad stop bit: hold off until the line is back to idle.
                    cnt_d = '0;
                    if (rx_s == StopBit) begin
                        ferr_d  = 1'b0;
                        state_d = RxIdle;
                    end
                end else if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (rx_s == StopBit) begin
                        valid_d = 1'b1;
                        state_d = RxIdle;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    // Receiver state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= 2'b11;
            state_q <= RxIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a registered serial output. Ready is also raised
// on the last cycle of the stop bit so back-to-back frames need no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter logic [15:0] Prescale  = 16'd1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o
);

    localparam logic [CntWidth-1:0] LastCnt  = bit_cycles(Prescale) - CntWidth'(1);
    localparam int unsigned         IdxWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(DataWidth - 1);

    tx_state_e            state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 stop_done;

    assign stop_done = (state_q == TxStop) && (cnt_q == LastCnt);
    assign ready_o   = (state_q == TxIdle) || stop_done;
    assign tx_o      = tx_q;

    // Next-state logic for the transmit FSM; tx_d is the line value for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntWidth'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        unique case (state_q)
            TxIdle: begin
                cnt_d = '0;
                tx_d  = StopBit;
                if (valid_i) begin
                    shift_d = data_i;
                    state_d = TxStart;
                    tx_d    = StartBit;
                end
            end
            TxStart: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TxData;
                    tx_d    = shift_q[0];
                end
            end
            TxData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = TxStop;
                        tx_d    = StopBit;
                    end else begin
                        idx_d   = idx_q + IdxWidth'(1);
                        shift_d = {1'b0, shift_q[DataWidth-1:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (valid_i) begin
                        shift_d = data_i;
                        state_d = TxStart;
                        tx_d    = StartBit;
                    end else begin
                        state_d = TxIdle;
                    end
                end
            end
            default: begin
                state_d = TxIdle;
                tx_d    = StopBit;
            end
        endcase
    end

    // Transmitter state registers; reset forces the line idle immediately.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= StopBit;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_loopback_echo.sv
// UART echo core: receiver -> one-entry holding register -> transmitter.
module uart_loopback_echo
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter logic [15:0] Prescale  = 16'd1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_data_i,
    output logic tx_data_o
);

    logic [DataWidth-1:0] rx_data;
    logic                 rx_valid;
    logic                 tx_ready;
    logic                 pop;

    logic                 hold_full_q, hold_full_d;
    logic [DataWidth-1:0] hold_data_q, hold_data_d;

    uart_rx #(
        .DataWidth (DataWidth),
        .Prescale  (Prescale)
    ) u_rx (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rx_i      (rx_data_i),
        .data_o    (rx_data),
        .valid_o   (rx_valid)
    );

    assign pop = hold_full_q && tx_ready;

    // Holding register: a write is accepted when empty or being popped this cycle;
    // otherwise the new byte is dropped and the stored one kept.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (pop) begin
            hold_full_d = 1'b0;
        end
        if (rx_valid && (!hold_full_q || pop)) begin
            hold_full_d = 1'b1;
            hold_data_d = rx_data;
        end
    end

    // Holding register state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end

    uart_tx #(
        .DataWidth (DataWidth),
        .Prescale  (Prescale)
    ) u_tx (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .data_i    (hold_data_q),
        .valid_i   (hold_full_q),
        .ready_o   (tx_ready),
        .tx_o      (tx_data_o)
    );

endmodule

// File: tb/tb_uart_loopback_echo.sv
// Self-checking bench for uart_loopback_echo: a driver serialises frames onto
// rx and queues the expected echo; a monitor decodes tx and checks it.
module tb_uart_loopback_echo;

    localparam logic [15:0] Prescale  = 16'd1;
    localparam int unsigned B         = 8;   // clock cycles per bit at Prescale 1
    localparam int unsigned ClkPeriod = 10;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic tx;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0] exp_q[$];
    longint     dl_q[$];   // latest acceptable tx start-bit sample time per frame

    logic        mon_en    = 1'b0;
    logic        mon_busy  = 1'b0;
    logic        mon_abort = 1'b0;
    int unsigned mon_frames   = 0;
    int unsigned mon_starts   = 0;
    int unsigned mon_last_gap = 0;

    uart_loopback_echo #(
        .DataWidth (8),
        .Prescale  (Prescale)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .rx_data_i (rx),
        .tx_data_o (tx)
    );

    always #(ClkPeriod / 2) clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one frame starting at the current negedge; optionally queue its echo.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_echo);
        longint t0;
        t0 = $time;
        if (expect_echo) begin
            exp_q.push_back(d);
            // 2 sync cycles, mid-stop sample, then at most 3 cycles to the tx start edge.
            dl_q.push_back(t0 + longint'((9 * B + B / 2 + 5) * ClkPeriod + ClkPeriod / 2));
        end
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        rx = stop;
        repeat (B) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 * B && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: decode tx frames, checking bit timing, stop bit, latency and data.
    initial begin : monitor
        int unsigned idle;
        longint      t_fall;
        int unsigned gap;
        logic        stable;
        logic        stop_ok;
        logic [7:0]  got;
        logic [7:0]  e;
        longint      dl;
        idle = 0;
        forever begin
            @(negedge clk);
            if (mon_en && tx == 1'b0) begin
                mon_busy = 1'b1;
                mon_starts++;
                t_fall = $time;
                gap    = idle;
                idle   = 0;
                stable = 1'b1;
                for (int s = 1; s < B; s++) begin
                    @(negedge clk);
                    if (tx !== 1'b0) stable = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    got[i] = tx;
                    for (int s = 1; s < B; s++) begin
                        @(negedge clk);
                        if (tx !== got[i]) stable = 1'b0;
                    end
                end
                stop_ok = 1'b1;
                for (int s = 0; s < B; s++) begin
                    @(negedge clk);
                    if (tx !== 1'b1) stop_ok = 1'b0;
                end
                if (mon_abort) begin
                    mon_abort = 1'b0;
                end else begin
                    mon_frames++;
                    mon_last_gap = gap;
                    check("echo_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) begin
                        e  = exp_q.pop_front();
                        dl = dl_q.pop_front();
                        check("echo_byte", got, e);
                        check("bit_timing", stable, 1);
                        check("stop_bit", stop_ok, 1);
                        check("echo_latency_ok", (t_fall <= dl) ? 1 : 0, 1);
                    end
                end
                mon_busy = 1'b0;
            end else if (tx == 1'b1) begin
                idle++;
            end
        end
    end

    initial begin : stimulus
        int unsigned f0;
        int unsigned s0;
        reset = 1'b1;
        rx    = 1'b1;

        // Reset with idle line, then 200 quiet cycles.
        repeat (2) begin
            @(negedge clk);
            check("tx_in_reset", tx, 1);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_no_start", mon_starts, 0);
        check("idle_tx_high", tx, 1);

        // Every byte value, one frame of idle after each.
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), 1'b1, 1'b1);
            repeat (10 * B) @(negedge clk);
        end
        drain("sweep_drain");
        check("sweep_frames", mon_frames, 256);

        // Back-to-back frames.
        f0 = mon_frames;
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b1);
        drain("b2b_drain");
        check("b2b_frames", mon_frames - f0, 2);
        check("b2b_gap_le3", (mon_last_gap <= 3) ? 1 : 0, 1);

        // Short low glitch must be rejected.
        s0 = mon_starts;
        rx = 1'b0;
        repeat (B / 2 - 2) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_echo", mon_starts - s0, 0);
        check("glitch_tx_high", tx, 1);

        // Framing error frame is discarded; the following good frame is echoed.
        f0 = mon_frames;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * B) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1);
        drain("ferr_drain");
        check("ferr_frames", mon_frames - f0, 1);

        // Reset in the middle of data bit 2 of an 0xF0 echo.
        send_frame(8'hF0, 1'b1, 1'b1);
        for (int i = 0; i < 4 * B && !mon_busy; i++) @(negedge clk);
        check("rst_tx_started", mon_busy, 1);
        repeat (3 * B + B / 2) @(negedge clk);
        check("rst_mid_data_bit", tx, 0);
        mon_abort = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_tx_idle_next", tx, 1);
        exp_q.delete();
        dl_q.delete();
        s0 = mon_starts;
        repeat (200) @(negedge clk);
        check("rst_no_output", mon_starts - s0, 0);
        f0 = mon_frames;
        send_frame(8'h5A, 1'b1, 1'b1);
        drain("rst_recover_drain");
        check("rst_recover_frames", mon_frames - f0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
